// File: rtl/uart_msg_seq.sv
// Feeds a fixed "HELLO\r\n" message byte by byte into the UART transmitter's
// load/load_byte/tx_ready handshake, on start or continuously with auto-repeat.
module uart_msg_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int MSG_LEN     = 7,
    parameter bit AUTO_REPEAT = 1'b0,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  tx_ready_i,
    output logic                  load_o,
    output logic [DATA_WIDTH-1:0] load_byte_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [2:0]            dbg_state_o
);
    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_LOAD     = 3'd2,
        S_ACCEPT   = 3'd3,
        S_DRAIN    = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic [GAP_W-1:0]        gap_cnt_q;
    logic                    load_q;
    logic [DATA_WIDTH-1:0]   load_byte_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] i);
        case (int'(i))
            0:       return 8'h48;
            1:       return 8'h45;
            2:       return 8'h4C;
            3:       return 8'h4C;
            4:       return 8'h4F;
            5:       return 8'h0D;
            6:       return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    // Handshake: load is a one-cycle pulse with load_byte valid; the transmitter
    // accepts by dropping tx_ready and signals completion by raising it again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            load_q      <= 1'b0;
            load_byte_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // A timeout parks auto-repeat until an explicit start.
                    if (start_i || (AUTO_REPEAT && !err_q)) begin
                        state_q <= S_WAIT_RDY;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                S_WAIT_RDY: begin
                    if (tx_ready_i) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    load_q      <= 1'b1;
                    load_byte_q <= DATA_WIDTH'(rom_byte(idx_q));
                    to_cnt_q    <= '0;
                    state_q     <= S_ACCEPT;
                end
                S_ACCEPT: begin
                    if (!tx_ready_i) begin
                        state_q <= S_DRAIN;
                    end else if (to_cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (tx_ready_i) begin
                        if (idx_q == IDX_LAST) begin
                            done_q <= 1'b1;
                            if (GAP_CYCLES == 0) begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                gap_cnt_q <= '0;
                                state_q   <= S_GAP;
                            end
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_o      = load_q;
    assign load_byte_o = load_byte_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_msg_seq.sv
// Bench for uart_msg_seq: one default instance (single-shot, 16-cycle gap) and
// one auto-repeat instance with no gap, each driven by a behavioural UART model.
module tb_uart_msg_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, start_a = 1'b0, rdy_a = 1'b1;
    logic       load_a, busy_a, done_a, err_a;
    logic [7:0] byte_a;
    logic [2:0] st_a;

    logic       rst_b = 1'b1, start_b = 1'b0, rdy_b = 1'b1;
    logic       load_b, busy_b, done_b, err_b;
    logic [7:0] byte_b;
    logic [2:0] st_b;

    uart_msg_seq dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .tx_ready_i(rdy_a),
        .load_o(load_a), .load_byte_o(byte_a), .busy_o(busy_a), .done_o(done_a),
        .err_o(err_a), .dbg_state_o(st_a)
    );

    uart_msg_seq #(.AUTO_REPEAT(1'b1), .GAP_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .tx_ready_i(rdy_b),
        .load_o(load_b), .load_byte_o(byte_b), .busy_o(busy_b), .done_o(done_b),
        .err_o(err_b), .dbg_state_o(st_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] msg [0:6];
    logic [7:0] exp_q [$];

    // Monitor and UART model state for instance A
    int a_loads = 0, a_dones = 0, a_first_load = -1, a_done_cyc = -1;
    int a_busy_fall = -1, a_err_rise = -1, a_ucnt = 0, a_low_len = 10;
    bit a_prev_busy = 1'b0, a_prev_err = 1'b0, a_rose = 1'b1;
    bit a_force_low = 1'b0, a_never_drop = 1'b0;

    // Monitor and UART model state for instance B
    int b_loads = 0, b_dones = 0, b_ucnt = 0;
    bit b_rose = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        logic nr;
        @(negedge clk);
        cyc++;
        if (load_a) begin
            a_loads++;
            if (a_first_load < 0) a_first_load = cyc;
            check("a_load_spacing", 32'(a_rose), 32'd1);
            a_rose = 1'b0;
            if (exp_q.size() > 0) check("a_byte", 32'(byte_a), 32'(exp_q.pop_front()));
            else check("a_unexpected_load", 32'(byte_a), 32'h100);
        end
        if (done_a) begin
            a_dones++;
            a_done_cyc = cyc;
        end
        if (a_prev_busy && !busy_a) a_busy_fall = cyc;
        if (err_a && !a_prev_err) begin
            a_err_rise = cyc;
            a_rose     = 1'b1;
        end
        a_prev_busy = busy_a;
        a_prev_err  = err_a;
        // Transmitter: ready drops the cycle after load and stays low a_low_len cycles.
        if (load_a) a_ucnt = a_low_len + 1;
        else if (a_ucnt > 0) a_ucnt--;
        nr = !a_force_low && (a_never_drop || a_ucnt == 0 || a_ucnt == a_low_len + 1);
        if (nr && !rdy_a) a_rose = 1'b1;
        rdy_a = nr;

        if (load_b) begin
            check("b_load_spacing", 32'(b_rose), 32'd1);
            b_rose = 1'b0;
            check("b_byte", 32'(byte_b), 32'(msg[b_loads % 7]));
            b_loads++;
        end
        if (done_b) b_dones++;
        if (load_b) b_ucnt = 11;
        else if (b_ucnt > 0) b_ucnt--;
        nr = (b_ucnt == 0 || b_ucnt == 11);
        if (nr && !rdy_b) b_rose = 1'b1;
        rdy_b = nr;
    endtask

    task automatic push_msg();
        for (int i = 0; i < 7; i++) exp_q.push_back(msg[i]);
    endtask

    task automatic clear_a();
        a_loads = 0; a_dones = 0; a_first_load = -1; a_done_cyc = -1;
        a_busy_fall = -1; a_err_rise = -1;
    endtask

    task automatic wait_idle_a(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (!busy_a) break;
        end
        if (i == budget) check("a_wait_budget", 32'(busy_a), 32'd0);
    endtask

    task automatic run_msg_a(input string tag);
        int s;
        clear_a();
        push_msg();
        start_a = 1'b1;
        s = cyc;
        tick();
        start_a = 1'b0;
        wait_idle_a(600);
        check({tag, "_loads"}, 32'(a_loads), 32'd7);
        check({tag, "_dones"}, 32'(a_dones), 32'd1);
        check({tag, "_gap"}, 32'(a_busy_fall - a_done_cyc), 32'd16);
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (s < 0) $display("unreachable");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, rel, p2, p5;
        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_load", 32'(load_a), 32'd0);
            check("rst_busy", 32'(busy_a), 32'd0);
            check("rst_done", 32'(done_a), 32'd0);
            check("rst_err", 32'(err_a), 32'd0);
            check("rst_byte", 32'(byte_a), 32'd0);
        end
        rst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_busy", 32'(busy_a), 32'd0);
            check("idle_load", 32'(load_a), 32'd0);
        end

        // Single message with start latency
        clear_a();
        push_msg();
        start_a = 1'b1;
        s = cyc;
        tick();
        start_a = 1'b0;
        check("msg_busy_on", 32'(busy_a), 32'd1);
        wait_idle_a(600);
        check("msg_first_latency", 32'(a_first_load - s), 32'd3);
        check("msg_loads", 32'(a_loads), 32'd7);
        check("msg_dones", 32'(a_dones), 32'd1);
        check("msg_gap", 32'(a_busy_fall - a_done_cyc), 32'd16);
        check("msg_exp_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Back-pressure: ready held low 20 cycles
        clear_a();
        push_msg();
        a_force_low = 1'b1;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (20) tick();
        check("bp_no_load", 32'(a_loads), 32'd0);
        a_force_low = 1'b0;
        tick();
        rel = cyc;
        wait_idle_a(600);
        check("bp_first_latency", 32'(a_first_load - rel), 32'd2);
        check("bp_loads", 32'(a_loads), 32'd7);
        check("bp_exp_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Acceptance timeout
        clear_a();
        exp_q.push_back(msg[0]);
        a_never_drop = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 300 && !err_a; i++) tick();
        check("to_err", 32'(err_a), 32'd1);
        check("to_latency", 32'(a_err_rise - a_first_load), 32'd64);
        check("to_busy", 32'(busy_a), 32'd0);
        repeat (30) tick();
        check("to_loads", 32'(a_loads), 32'd1);
        check("to_err_sticky", 32'(err_a), 32'd1);
        a_never_drop = 1'b0;
        repeat (2) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("to_err_cleared", 32'(err_a), 32'd0);
        clear_a();
        push_msg();
        wait_idle_a(600);
        check("to_recover_loads", 32'(a_loads), 32'd7);
        exp_q.delete();

        // Start pulses during bytes 2 and 5 are ignored
        clear_a();
        push_msg();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        p2 = 0; p5 = 0;
        for (int i = 0; i < 600 && busy_a; i++) begin
            start_a = ((a_loads == 2 && p2 == 0) || (a_loads == 5 && p5 == 0));
            if (a_loads == 2) p2 = 1;
            if (a_loads == 5) p5 = 1;
            tick();
        end
        start_a = 1'b0;
        repeat (40) tick();
        check("busy_start_loads", 32'(a_loads), 32'd7);
        check("busy_start_dones", 32'(a_dones), 32'd1);
        check("busy_start_idle", 32'(busy_a), 32'd0);
        exp_q.delete();

        // Randomized transmitter speed and back-pressure
        for (int r = 0; r < 4; r++) begin
            a_low_len = $urandom_range(1, 15);
            repeat ($urandom_range(0, 5)) tick();
            if ($urandom_range(0, 1) == 1) begin
                a_force_low = 1'b1;
                tick();
                start_a = 1'b1;
                clear_a();
                push_msg();
                tick();
                start_a = 1'b0;
                repeat ($urandom_range(1, 8)) tick();
                a_force_low = 1'b0;
                wait_idle_a(800);
                check("rnd_bp_loads", 32'(a_loads), 32'd7);
                check("rnd_bp_gap", 32'(a_busy_fall - a_done_cyc), 32'd16);
                exp_q.delete();
            end else begin
                run_msg_a("rnd");
            end
        end
        a_low_len = 10;

        // Auto-repeat instance, no gap; reset in the middle of byte 3
        rst_b = 1'b0;
        for (int i = 0; i < 600 && b_loads < 10; i++) tick();
        check("ar_loads_reached", 32'(b_loads), 32'd10);
        check("ar_first_done", 32'(b_dones), 32'd1);
        repeat (4) tick();
        rst_b = 1'b1;
        tick();
        check("ar_rst_load", 32'(load_b), 32'd0);
        check("ar_rst_busy", 32'(busy_b), 32'd0);
        rst_b = 1'b0;
        b_loads = 0;
        b_dones = 0;
        for (int i = 0; i < 600 && b_loads < 8; i++) tick();
        check("ar_restart_loads", 32'(b_loads), 32'd8);
        check("ar_restart_dones", 32'(b_dones), 32'd1);
        check("ar_err", 32'(err_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
